lif_neuron: RTL and testbench
=============================

# lif_neuron

Single leaky integrate-and-fire neuron core for the LIF demonstrator. It integrates an 8-bit input current once per step strobe, applies a shift-based leak, fires a one-cycle spike when the membrane potential crosses threshold, then holds in a refractory period. It sits upstream of the threshold-LED/UART reporting logic: `v_mem` replaces the free-running ramp as the monitored quantity, and `spike` drives spike reporting.

## Interface
- `V_WIDTH`, 8: membrane potential and input width.
- `V_TH`, 200: firing threshold. A spike occurs when the potential is ≥ `V_TH`.
- `V_RESET`, 0: potential loaded after a spike and held through the refractory period.
- `LEAK_SHIFT`, 4: leak per step is `v_mem >> LEAK_SHIFT`.
- `REF_TICKS`, 3: number of refractory steps after a spike (0 means none).
- `clk` in 1: board clock, 12 MHz.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `tick` in 1: one-cycle step strobe, typically the 1 ms or slowed tick.
- `en` in 1: enable. When low, `tick` is ignored and all state is frozen.
- `i_in` in `V_WIDTH`: input current, sampled on the `tick` cycle.
- `v_mem` out `V_WIDTH`: registered membrane potential.
- `spike` out 1: one-cycle registered spike pulse.
- `refractory` out 1: high while in the REFRACT state.
- `spike_count` out 16: spikes since reset, saturating at 0xFFFF.

## Operation
- Reset values: `v_mem`=0, `spike`=0, `refractory`=0, `spike_count`=0, state=INTEGRATE, refractory counter=0.
- A step occurs in a cycle where `tick`=1 and `en`=1. In all other cycles nothing changes except that `spike` returns to 0.
- **INTEGRATE step:**
  - `sum = v_mem - (v_mem >> LEAK_SHIFT) + i_in`, computed at `V_WIDTH+1` bits.
  - If `sum` exceeds 2^`V_WIDTH`-1, saturate it to that value.
  - If the saturated sum is ≥ `V_TH`:
    - `spike`←1 and `v_mem`←`V_RESET`.
    - `spike_count` increments, saturating at 0xFFFF.
    - If `REF_TICKS`>0: go to REFRACT and set the counter to `REF_TICKS`.
  - Otherwise `v_mem`←saturated sum.
- **REFRACT step:**
  - `i_in` is ignored and `v_mem` holds `V_RESET`.
  - The counter decrements. On the step where it reaches 0, return to INTEGRATE. Integration resumes on the following step.
- The leak uses a floor shift. For `v_mem` < 2^`LEAK_SHIFT` the leak is 0, so the potential can sit below threshold indefinitely with `i_in`=0. This is intended.
- Dropping `en` in REFRACT freezes the counter. The remaining refractory steps complete after `en` returns.
- `tick` and an `en` edge in the same cycle: the `en` value in that cycle decides whether the step happens.
- Asserting `rst_n` mid-refractory or mid-spike returns every output to its reset value immediately (asynchronous).

## Timing
- Step latency is 1 cycle. A tick in cycle n produces updated `v_mem`, `spike` and `refractory` in cycle n+1.
- `spike` is high for exactly one clk cycle per firing, independent of tick spacing.
- `refractory` rises in the same cycle as `spike`. It falls in the cycle after the final refractory step.
- `spike_count` updates in the same cycle as `spike`.
- All outputs are registered; there are no combinational input-to-output paths.
- Ticks closer together than 2 cycles are legal; each one is a step.

## Structure
- The shared package `lif_pkg` holds:
  - the state encoding: `ST_INTEGRATE`, `ST_REFRACT`;
  - the default constants: `V_WIDTH`, `V_TH`, `V_RESET`, `LEAK_SHIFT`, `REF_TICKS`;
  - the 16-bit count width.
- One sub-module is natural: `lif_sat_add`. It is combinational and computes leak, add and saturate at `V_WIDTH+1` bits. It is reused by future multi-neuron arrays.
- The FSM, refractory counter and spike counter live in `lif_neuron` itself.

## Test plan
1. **Reset and idle.** Hold `rst_n`=0, then release with `i_in`=0 and 10 ticks → `v_mem`=0, `spike`=0, `refractory`=0, `spike_count`=0 throughout.
2. **Integration trajectory.** Defaults, `i_in`=50 constant → `v_mem` after ticks 1–4 is 50, 97, 141, 183. Tick 5 gives `spike`=1 for one cycle, `v_mem`=0 and `spike_count`=1. Ticks 6–8 are refractory with `v_mem`=0. Tick 9 gives `v_mem`=50.
3. **Saturation.** `v_mem`=0, `i_in`=255 → the first tick fires (saturated 255 ≥ 200), `v_mem`=0, with no wrap artefacts. Repeat with `V_TH`=255 and `i_in`=255 from `v_mem`=240: the sum saturates to 255 and fires.
4. **Enable gating.** `en`=0 for 5 ticks mid-integration (`v_mem`=97) → `v_mem` stays 97. `en`=0 during refractory after 1 step → after re-enable, exactly 2 more refractory steps occur before integration resumes.
5. **Reset mid-refractory.** Pulse `rst_n` low asynchronously between clock edges during REFRACT → all outputs are 0 at once, and the next tick with `i_in`=50 gives `v_mem`=50.
6. **Back-to-back ticks.** Ticks on consecutive cycles with `i_in`=100, `V_TH`=200, `REF_TICKS`=0 → `v_mem` reads 100, then 194, then a spike and 0, then 100. `spike` is a single-cycle pulse.

Source files
------------

// File: rtl/lif_pkg.sv
// lif_pkg: shared state encoding and default constants for LIF neuron blocks
package lif_pkg;
    typedef enum logic {ST_INTEGRATE, ST_REFRACT} state_t;
    localparam int V_WIDTH    = 8;
    localparam int V_TH       = 200;
    localparam int V_RESET    = 0;
    localparam int LEAK_SHIFT = 4;
    localparam int REF_TICKS  = 3;
    localparam int CNT_WIDTH  = 16;
endpackage

// File: rtl/lif_sat_add.sv
// lif_sat_add: one leak-and-integrate step, saturating at the top of the V_WIDTH range
module lif_sat_add #(
    parameter int V_WIDTH    = lif_pkg::V_WIDTH,
    parameter int LEAK_SHIFT = lif_pkg::LEAK_SHIFT
) (
    input  logic [V_WIDTH-1:0] v,
    input  logic [V_WIDTH-1:0] i,
    output logic [V_WIDTH-1:0] sum
);
    logic [V_WIDTH:0] s;
    // v - (v >> LEAK_SHIFT) never goes negative, so only the top bit needs clamping
    assign s   = {1'b0, v} - ({1'b0, v} >> LEAK_SHIFT) + {1'b0, i};
    assign sum = s[V_WIDTH] ? {V_WIDTH{1'b1}} : s[V_WIDTH-1:0];
endmodule

// File: rtl/lif_neuron.sv
// lif_neuron: leaky integrate-and-fire neuron with refractory hold and saturating spike counter
module lif_neuron #(
    parameter int V_WIDTH    = lif_pkg::V_WIDTH,
    parameter int V_TH       = lif_pkg::V_TH,
    parameter int V_RESET    = lif_pkg::V_RESET,
    parameter int LEAK_SHIFT = lif_pkg::LEAK_SHIFT,
    parameter int REF_TICKS  = lif_pkg::REF_TICKS
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           tick,
    input  logic                           en,
    input  logic [V_WIDTH-1:0]             i_in,
    output logic [V_WIDTH-1:0]             v_mem,
    output logic                           spike,
    output logic                           refractory,
    output logic [lif_pkg::CNT_WIDTH-1:0]  spike_count
);
    import lif_pkg::*;
    localparam int RW = (REF_TICKS > 0) ? $clog2(REF_TICKS + 1) : 1;
    state_t             state;
    logic [RW-1:0]      cnt;
    logic [V_WIDTH-1:0] sum;
    lif_sat_add #(.V_WIDTH(V_WIDTH), .LEAK_SHIFT(LEAK_SHIFT)) u_add (
        .v   (v_mem),
        .i   (i_in),
        .sum (sum)
    );
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_INTEGRATE;
            cnt         <= '0;
            v_mem       <= '0;
            spike       <= 1'b0;
            refractory  <= 1'b0;
            spike_count <= '0;
        end else begin
            spike <= 1'b0;
            if (tick && en) begin
                if (state == ST_INTEGRATE) begin
                    if (sum >= V_WIDTH'(V_TH)) begin
                        spike <= 1'b1;
                        v_mem <= V_WIDTH'(V_RESET);
                        if (spike_count != '1) spike_count <= spike_count + CNT_WIDTH'(1);
                        if (REF_TICKS > 0) begin
                            state      <= ST_REFRACT;
                            refractory <= 1'b1;
                            cnt        <= RW'(REF_TICKS);
                        end
                    end else begin
                        v_mem <= sum;
                    end
                end else begin
                    v_mem <= V_WIDTH'(V_RESET);
                    cnt   <= cnt - RW'(1);
                    if (cnt == RW'(1)) begin
                        state      <= ST_INTEGRATE;
                        refractory <= 1'b0;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_lif_neuron.sv
// tb_lif_neuron: scoreboard bench over three neuron configurations sharing one stimulus
module tb_lif_neuron;
    logic        clk = 1'b0, rst_n = 1'b0, tick = 1'b0, en = 1'b1;
    logic [7:0]  i_in = 8'd0;
    logic [7:0]  v_mem [3];
    logic        spike [3];
    logic        refractory [3];
    logic [15:0] spike_count [3];
    int errors = 0, checks = 0;

    // rs: reset before this step, d: which neuron (0 default, 1 V_TH=255, 2 REF_TICKS=0)
    typedef struct packed {
        logic rs; logic [7:0] i; logic e; logic [1:0] d;
        logic [7:0] v; logic s; logic r; logic [15:0] c;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    lif_neuron dut0 (.clk(clk), .rst_n(rst_n), .tick(tick), .en(en), .i_in(i_in),
        .v_mem(v_mem[0]), .spike(spike[0]), .refractory(refractory[0]), .spike_count(spike_count[0]));
    lif_neuron #(.V_TH(255)) dut1 (.clk(clk), .rst_n(rst_n), .tick(tick), .en(en), .i_in(i_in),
        .v_mem(v_mem[1]), .spike(spike[1]), .refractory(refractory[1]), .spike_count(spike_count[1]));
    lif_neuron #(.REF_TICKS(0)) dut2 (.clk(clk), .rst_n(rst_n), .tick(tick), .en(en), .i_in(i_in),
        .v_mem(v_mem[2]), .spike(spike[2]), .refractory(refractory[2]), .spike_count(spike_count[2]));

    function automatic exp_t mk(int rs, int i, int e, int d, int v, int s, int r, int c);
        mk = '{rs[0], i[7:0], e[0], d[1:0], v[7:0], s[0], r[0], c[15:0]};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; tick = 1'b0; en = 1'b1; i_in = 8'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic tick_once(input logic [7:0] i, input logic e);
        @(negedge clk);
        i_in = i; en = e; tick = 1'b1;
        @(negedge clk);
        tick = 1'b0; en = 1'b1;
    endtask

    task automatic test_reset();
        exp_t x;
        rst_n = 1'b0; tick = 1'b0; en = 1'b1; i_in = 8'd0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({v_mem[d], spike[d], refractory[d], spike_count[d]} !== 26'd0) begin
                errors++;
                $display("FAIL reset_hold dut%0d: got %h want 0", d, {v_mem[d], spike[d], refractory[d], spike_count[d]});
            end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            sb.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0));
            tick_once(8'd0, 1'b1);
            x = sb.pop_front();
            checks++;
            if ({v_mem[x.d], spike[x.d], refractory[x.d], spike_count[x.d]} !== {x.v, x.s, x.r, x.c}) begin
                errors++;
                $display("FAIL reset_idle step %0d: got %h want %h", k, {v_mem[x.d], spike[x.d], refractory[x.d], spike_count[x.d]}, {x.v, x.s, x.r, x.c});
            end
        end
    endtask

    task automatic test_integrate();
        exp_t x;
        exp_t t[9];
        t = '{mk(1,50,1,0, 50,0,0,0), mk(0,50,1,0, 97,0,0,0), mk(0,50,1,0,141,0,0,0),
              mk(0,50,1,0,183,0,0,0), mk(0,50,1,0,  0,1,1,1), mk(0,50,1,0,  0,0,1,1),
              mk(0,50,1,0,  0,0,1,1), mk(0,50,1,0,  0,0,0,1), mk(0,50,1,0, 50,0,0,1)};
        foreach (t[k]) begin
            if (t[k].rs) do_reset();
            sb.push_back(t[k]);
            tick_once(t[k].i, t[k].e);
            x = sb.pop_front();
            checks++;
            if ({v_mem[x.d], spike[x.d], refractory[x.d], spike_count[x.d]} !== {x.v, x.s, x.r, x.c}) begin
                errors++;
                $display("FAIL integrate step %0d: got %h want %h", k, {v_mem[x.d], spike[x.d], refractory[x.d], spike_count[x.d]}, {x.v, x.s, x.r, x.c});
            end
        end
    endtask

    task automatic test_saturation();
        exp_t x;
        exp_t t[3];
        t = '{mk(1,255,1,0,  0,1,1,1),
              mk(1,240,1,1,240,0,0,0), mk(0,255,1,1,  0,1,1,1)};
        foreach (t[k]) begin
            if (t[k].rs) do_reset();
            sb.push_back(t[k]);
            tick_once(t[k].i, t[k].e);
            x = sb.pop_front();
            checks++;
            if ({v_mem[x.d], spike[x.d], refractory[x.d], spike_count[x.d]} !== {x.v, x.s, x.r, x.c}) begin
                errors++;
                $display("FAIL saturation step %0d: got %h want %h", k, {v_mem[x.d], spike[x.d], refractory[x.d], spike_count[x.d]}, {x.v, x.s, x.r, x.c});
            end
        end
    endtask

    task automatic test_enable();
        exp_t x;
        exp_t t[17];
        t = '{mk(1,50,1,0, 50,0,0,0), mk(0,50,1,0, 97,0,0,0),
              mk(0,50,0,0, 97,0,0,0), mk(0,50,0,0, 97,0,0,0), mk(0,50,0,0, 97,0,0,0),
              mk(0,50,0,0, 97,0,0,0), mk(0,50,0,0, 97,0,0,0),
              mk(0,50,1,0,141,0,0,0), mk(0,50,1,0,183,0,0,0), mk(0,50,1,0,  0,1,1,1),
              mk(0,50,1,0,  0,0,1,1),
              mk(0,50,0,0,  0,0,1,1), mk(0,50,0,0,  0,0,1,1), mk(0,50,0,0,  0,0,1,1),
              mk(0,50,1,0,  0,0,1,1), mk(0,50,1,0,  0,0,0,1), mk(0,50,1,0, 50,0,0,1)};
        foreach (t[k]) begin
            if (t[k].rs) do_reset();
            sb.push_back(t[k]);
            tick_once(t[k].i, t[k].e);
            x = sb.pop_front();
            checks++;
            if ({v_mem[x.d], spike[x.d], refractory[x.d], spike_count[x.d]} !== {x.v, x.s, x.r, x.c}) begin
                errors++;
                $display("FAIL enable step %0d: got %h want %h", k, {v_mem[x.d], spike[x.d], refractory[x.d], spike_count[x.d]}, {x.v, x.s, x.r, x.c});
            end
        end
    endtask

    task automatic test_reset_mid_refract();
        exp_t x;
        do_reset();
        tick_once(8'd255, 1'b1);
        checks++;
        if ({spike[0], refractory[0]} !== 2'b11) begin
            errors++;
            $display("FAIL pre_reset_spike: got %b want 11", {spike[0], refractory[0]});
        end
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if ({v_mem[d], spike[d], refractory[d], spike_count[d]} !== 26'd0) begin
                errors++;
                $display("FAIL async_reset dut%0d: got %h want 0", d, {v_mem[d], spike[d], refractory[d], spike_count[d]});
            end
        end
        #1 rst_n = 1'b1;
        sb.push_back(mk(0, 50, 1, 0, 50, 0, 0, 0));
        tick_once(8'd50, 1'b1);
        x = sb.pop_front();
        checks++;
        if ({v_mem[x.d], spike[x.d], refractory[x.d], spike_count[x.d]} !== {x.v, x.s, x.r, x.c}) begin
            errors++;
            $display("FAIL after_async_reset: got %h want %h", {v_mem[x.d], spike[x.d], refractory[x.d], spike_count[x.d]}, {x.v, x.s, x.r, x.c});
        end
    endtask

    task automatic test_back_to_back();
        exp_t x;
        do_reset();
        sb.push_back(mk(0,100,1,2,100,0,0,0));
        sb.push_back(mk(0,100,1,2,194,0,0,0));
        sb.push_back(mk(0,100,1,2,  0,1,0,1));
        sb.push_back(mk(0,100,1,2,100,0,0,1));
        sb.push_back(mk(0,100,0,2,100,0,0,1));
        @(negedge clk);
        i_in = 8'd100; en = 1'b1; tick = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            x = sb.pop_front();
            tick = (sb.size() > 1);
            checks++;
            if ({v_mem[x.d], spike[x.d], refractory[x.d], spike_count[x.d]} !== {x.v, x.s, x.r, x.c}) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got %h want %h", k, {v_mem[x.d], spike[x.d], refractory[x.d], spike_count[x.d]}, {x.v, x.s, x.r, x.c});
            end
        end
        tick = 1'b0;
    endtask

    initial begin
        test_reset();
        test_integrate();
        test_saturation();
        test_enable();
        test_reset_mid_refract();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
